// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin scheduler that shares one combinational add/multiply
// ALU between two requesters. Operands are registered and held on the ALU for
// an op-dependent number of cycles. The captured result is then returned on a
// single response channel that is tagged with the requester id.
//
// Handshake semantics (all channels): a transfer happens on a rising clk_i edge
// where valid and ready are both high. Valid must not depend on ready. A
// requester keeps op/a/b stable while valid is high and ready is low. Ready may
// depend combinationally on valid (reqN_rdy_o does). resp_v_o is held with
// stable data/id until resp_rdy_i is seen high.
module alu_arbiter #(
    parameter int W       = 128,
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req0_v_i,
    output logic         req0_rdy_o,
    input  logic         req0_op_i,
    input  logic [W-1:0] req0_a_i,
    input  logic [W-1:0] req0_b_i,
    input  logic         req1_v_i,
    output logic         req1_rdy_o,
    input  logic         req1_op_i,
    input  logic [W-1:0] req1_a_i,
    input  logic [W-1:0] req1_b_i,
    output logic         alu_op_o,
    output logic [W-1:0] alu_a_o,
    output logic [W-1:0] alu_b_o,
    input  logic [W-1:0] alu_result_i,
    output logic         resp_v_o,
    input  logic         resp_rdy_i,
    output logic         resp_id_o,
    output logic [W-1:0] resp_data_o,
    // Debug view of the FSM: 0=IDLE, 1=EXEC, 2=RESP
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] ADD_CNT = CW'(ADD_LAT - 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_grant;  // id granted at the most recent accept
    logic          op_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          id_q;
    logic [W-1:0]  result_q;

    logic          gnt0;
    logic          gnt1;
    logic          accept;

    // Round-robin grant: a lone valid wins; on a tie the requester not granted last time wins
    always_comb begin
        gnt0       = req0_v_i & (~req1_v_i | last_grant);
        gnt1       = req1_v_i & (~req0_v_i | ~last_grant);
        req0_rdy_o = (state == IDLE) & gnt0;
        req1_rdy_o = (state == IDLE) & gnt1;
        accept     = req0_rdy_o | req1_rdy_o;
    end

    // Control FSM with operand, result and pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q       <= req1_rdy_o;
                        last_grant <= req1_rdy_o;
                        op_q       <= req1_rdy_o ? req1_op_i : req0_op_i;
                        a_q        <= req1_rdy_o ? req1_a_i : req0_a_i;
                        b_q        <= req1_rdy_o ? req1_b_i : req0_b_i;
                        cnt        <= (req1_rdy_o ? req1_op_i : req0_op_i) ? MUL_CNT : ADD_CNT;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable for the full latency once the count reaches zero
                    if (cnt == '0) begin
                        result_q <= alu_result_i;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_rdy_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are taken straight from registers
    always_comb begin
        alu_op_o    = op_q;
        alu_a_o     = a_q;
        alu_b_o     = b_q;
        resp_v_o    = (state == RESP);
        resp_id_o   = id_q;
        resp_data_o = result_q;
        dbg_state   = state;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: table of single-requester ops plus hand-written
// sequences for reset, contention, backpressure and reset during a multiply.
module tb_alu_arbiter;

    localparam int W       = 128;
    localparam int ADD_LAT = 1;
    localparam int MUL_LAT = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         req0_v_i, req0_rdy_o, req0_op_i;
    logic [W-1:0] req0_a_i, req0_b_i;
    logic         req1_v_i, req1_rdy_o, req1_op_i;
    logic [W-1:0] req1_a_i, req1_b_i;
    logic         alu_op_o;
    logic [W-1:0] alu_a_o, alu_b_o, alu_result_i;
    logic         resp_v_o, resp_rdy_i, resp_id_o;
    logic [W-1:0] resp_data_o;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         id;
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic         exp_id_q[$];
    logic         acc_id_q[$];
    int           acc_cyc_q[$];

    // Clock and reference ALU (the combinational block the arbiter drives)
    always #5 clk_i = ~clk_i;
    assign alu_result_i = alu_op_o ? (alu_a_o * alu_b_o) : (alu_a_o + alu_b_o);

    alu_arbiter #(.W(W), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_v_i(req0_v_i), .req0_rdy_o(req0_rdy_o), .req0_op_i(req0_op_i),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
        .req1_v_i(req1_v_i), .req1_rdy_o(req1_rdy_o), .req1_op_i(req1_op_i),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_result_i(alu_result_i),
        .resp_v_o(resp_v_o), .resp_rdy_i(resp_rdy_i), .resp_id_o(resp_id_o),
        .resp_data_o(resp_data_o), .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            req1_v_i = v; req1_op_i = op; req1_a_i = a; req1_b_i = b;
        end else begin
            req0_v_i = v; req0_op_i = op; req0_a_i = a; req0_b_i = b;
        end
    endtask

    // One op from one requester with resp_rdy_i high; checks latency, ALU hold and response
    task automatic do_op(input vec_t v);
        int lat;
        lat = v.op ? MUL_LAT : ADD_LAT;
        @(negedge clk_i);
        set_req(v.id, 1'b1, v.op, v.a, v.b);
        #1;
        check("rdy_granted", W'(v.id ? req1_rdy_o : req0_rdy_o), W'(1));
        check("rdy_other", W'(v.id ? req0_rdy_o : req1_rdy_o), W'(0));
        @(posedge clk_i);
        #1;
        set_req(v.id, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk_i);
            check("exec_resp_v", W'(resp_v_o), W'(0));
            check("exec_alu_op", W'(alu_op_o), W'(v.op));
            check("exec_alu_a", alu_a_o, v.a);
            check("exec_alu_b", alu_b_o, v.b);
            @(posedge clk_i);
        end
        @(negedge clk_i);
        check("resp_v", W'(resp_v_o), W'(1));
        check("resp_data", resp_data_o, v.exp);
        check("resp_id", W'(resp_id_o), W'(v.id));
        @(posedge clk_i);
        @(negedge clk_i);
        check("resp_v_after_hs", W'(resp_v_o), W'(0));
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] lo64;
        int c;
        ones = '1;
        lo64 = {64'd0, {64{1'b1}}};
        vecs[0] = '{id: 1'b0, op: 1'b0, a: W'(5), b: W'(7), exp: W'(12)};
        vecs[1] = '{id: 1'b1, op: 1'b1, a: {1'b1, 125'd0, 2'd3}, b: W'(2), exp: W'(6)};
        vecs[2] = '{id: 1'b0, op: 1'b0, a: ones, b: W'(1), exp: W'(0)};
        vecs[3] = '{id: 1'b1, op: 1'b0, a: W'(100), b: W'(23), exp: W'(123)};
        vecs[4] = '{id: 1'b0, op: 1'b1, a: lo64, b: lo64,
                    exp: {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001}};
        vecs[5] = '{id: 1'b1, op: 1'b1, a: W'(3), b: W'(7), exp: W'(21)};
        vecs[6] = '{id: 1'b0, op: 1'b1, a: ones, b: ones, exp: W'(1)};

        // Reset block
        rst_ni = 1'b0;
        resp_rdy_i = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        #3;
        check("rst_resp_v", W'(resp_v_o), W'(0));
        check("rst_state", W'(dbg_state), W'(0));
        #9 rst_ni = 1'b1;

        // Ready follows valid combinationally in IDLE
        @(negedge clk_i);
        check("idle_rdy0_novalid", W'(req0_rdy_o), W'(0));
        check("idle_rdy1_novalid", W'(req1_rdy_o), W'(0));
        #1 req0_v_i = 1'b1;
        #1;
        check("idle_rdy0_same_cycle", W'(req0_rdy_o), W'(1));
        check("idle_rdy1_not_granted", W'(req1_rdy_o), W'(0));
        #1 req0_v_i = 1'b0;

        // Table-driven single-requester ops
        for (int i = 0; i < 7; i++) do_op(vecs[i]);

        // Contention right after reset: expect accepts 0,1,0,1 spaced L+2 apart
        @(negedge clk_i);
        rst_ni = 1'b0;
        #2 rst_ni = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, W'(1), W'(1));
        set_req(1'b1, 1'b1, 1'b0, W'(10), W'(20));
        exp_id_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_q = '{W'(2), W'(30), W'(2), W'(30)};
        #1;
        c = 0;
        while (got_q.size() < 4 && c < 40) begin
            if (req0_rdy_o && req1_rdy_o) check("both_ready", W'(1), W'(0));
            if (req0_rdy_o) begin acc_id_q.push_back(1'b0); acc_cyc_q.push_back(c); end
            if (req1_rdy_o) begin acc_id_q.push_back(1'b1); acc_cyc_q.push_back(c); end
            if (resp_v_o) got_q.push_back(resp_data_o);
            if (got_q.size() < 4) begin
                @(negedge clk_i);
                c++;
            end
        end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        check("contention_resp_count", W'(got_q.size()), W'(4));
        check("contention_acc_count", W'(acc_id_q.size()), W'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < acc_id_q.size()) begin
                check("contention_order", W'(acc_id_q[i]), W'(exp_id_q[i]));
                if (i > 0) check("contention_gap", W'(acc_cyc_q[i] - acc_cyc_q[i-1]), W'(ADD_LAT + 2));
            end
            if (i < got_q.size()) check("contention_data", got_q[i], exp_q[i]);
        end

        // Backpressure: response held for 5 cycles, no accept meanwhile
        @(negedge clk_i);
        resp_rdy_i = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, W'(9), W'(10));
        #1;
        check("bp_rdy0", W'(req0_rdy_o), W'(1));
        @(posedge clk_i);
        #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b1, 1'b0, W'(1), W'(1));
        @(negedge clk_i);
        check("bp_exec_rdy1", W'(req1_rdy_o), W'(0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check("bp_resp_v", W'(resp_v_o), W'(1));
            check("bp_resp_data", resp_data_o, W'(19));
            check("bp_resp_id", W'(resp_id_o), W'(0));
            check("bp_rdy0_low", W'(req0_rdy_o), W'(0));
            check("bp_rdy1_low", W'(req1_rdy_o), W'(0));
        end
        resp_rdy_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("bp_after_hs_resp_v", W'(resp_v_o), W'(0));
        check("bp_after_hs_rdy1", W'(req1_rdy_o), W'(1));
        @(posedge clk_i);
        #1 set_req(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("bp_next_resp_v", W'(resp_v_o), W'(1));
        check("bp_next_resp_data", resp_data_o, W'(2));
        check("bp_next_resp_id", W'(resp_id_o), W'(1));
        @(posedge clk_i);

        // Reset during EXEC of a multiply granted to req0
        @(negedge clk_i);
        set_req(1'b0, 1'b1, 1'b1, W'(3), W'(5));
        @(posedge clk_i);
        #1 set_req(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk_i);
        check("mid_exec_alu_a", alu_a_o, W'(3));
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_alu_a", alu_a_o, W'(0));
        check("async_rst_alu_b", alu_b_o, W'(0));
        check("async_rst_alu_op", W'(alu_op_o), W'(0));
        check("async_rst_resp_v", W'(resp_v_o), W'(0));
        check("async_rst_resp_data", resp_data_o, W'(0));
        check("async_rst_resp_id", W'(resp_id_o), W'(0));
        #1 rst_ni = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            check("post_rst_no_resp", W'(resp_v_o), W'(0));
        end
        set_req(1'b0, 1'b1, 1'b0, W'(4), W'(4));
        set_req(1'b1, 1'b1, 1'b0, W'(6), W'(6));
        #1;
        check("post_rst_tie_rdy0", W'(req0_rdy_o), W'(1));
        check("post_rst_tie_rdy1", W'(req1_rdy_o), W'(0));
        @(posedge clk_i);
        #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("post_rst_resp_data", resp_data_o, W'(8));
        check("post_rst_resp_id", W'(resp_id_o), W'(0));
        @(posedge clk_i);
        @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
